// File: rtl/hzd_unit_pkg.sv
// Shared constants for the Tnew/Tuse hazard unit: forward-select codes,
// the "operand not read" Tuse code and register-number width.
package hzd_unit_pkg;

    localparam int unsigned REG_W     = 5;
    localparam int unsigned TUSE_NONE = 3;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    // Record index 0/1/2 is the E/M/W stage.
    function automatic fwd_sel_e stage_fwd(input int unsigned k);
        if (k == 0) return FWD_E;
        if (k == 1) return FWD_M;
        return FWD_W;
    endfunction

endpackage

// File: rtl/hzd_unit_stage_rec.sv
// One pipeline-stage hazard record: async clear, bubble insertion and an
// optional saturating Tnew decrement on load.
module hzd_stage_rec
    import hzd_unit_pkg::*;
#(
    parameter int unsigned TN_W     = 2,
    parameter bit          DEC_TNEW = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble,
    input  logic             in_valid,
    input  logic             in_wen,
    input  logic [REG_W-1:0] in_dst,
    input  logic [TN_W-1:0]  in_tnew,
    input  logic [REG_W-1:0] in_rs,
    input  logic [REG_W-1:0] in_rt,
    output logic             q_valid,
    output logic             q_wen,
    output logic [REG_W-1:0] q_dst,
    output logic [TN_W-1:0]  q_tnew,
    output logic [REG_W-1:0] q_rs,
    output logic [REG_W-1:0] q_rt
);

    logic             valid_q, valid_d;
    logic             wen_q, wen_d;
    logic [REG_W-1:0] dst_q, dst_d;
    logic [TN_W-1:0]  tnew_q, tnew_d;
    logic [REG_W-1:0] rs_q, rs_d;
    logic [REG_W-1:0] rt_q, rt_d;

    function automatic logic [TN_W-1:0] sat_dec(input logic [TN_W-1:0] v);
        return (v == '0) ? '0 : v - TN_W'(1);
    endfunction

    always_comb begin
        valid_d = 1'b0;
        wen_d   = 1'b0;
        dst_d   = '0;
        tnew_d  = '0;
        rs_d    = '0;
        rt_d    = '0;
        if (!bubble) begin
            valid_d = in_valid;
            wen_d   = in_wen;
            dst_d   = in_dst;
            tnew_d  = DEC_TNEW ? sat_dec(in_tnew) : in_tnew;
            rs_d    = in_rs;
            rt_d    = in_rt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wen_q   <= 1'b0;
            dst_q   <= '0;
            tnew_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
        end else begin
            valid_q <= valid_d;
            wen_q   <= wen_d;
            dst_q   <= dst_d;
            tnew_q  <= tnew_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
        end
    end

    assign q_valid = valid_q;
    assign q_wen   = wen_q;
    assign q_dst   = dst_q;
    assign q_tnew  = tnew_q;
    assign q_rs    = rs_q;
    assign q_rt    = rt_q;

endmodule

// File: rtl/hzd_unit.sv
// Tnew/Tuse hazard unit beside the D stage: F/D stall and forwarding selects.
// Optional HZD_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module hzd_unit
    import hzd_unit_pkg::*;
#(
    parameter int unsigned TN_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [TN_W-1:0]  id_tuse_rs,
    input  logic [TN_W-1:0]  id_tuse_rt,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wdst,
    input  logic [TN_W-1:0]  id_tninit,
    output logic             stall,
    output logic [1:0]       fwd_d_rs,
    output logic [1:0]       fwd_d_rt,
    output logic [1:0]       fwd_e_rs,
    output logic [1:0]       fwd_e_rt,
    output logic [1:0]       fwd_m_rt
`ifdef HZD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // Index 0 = E, 1 = M, 2 = W
    logic             rec_valid [3];
    logic             rec_wen   [3];
    logic [REG_W-1:0] rec_dst   [3];
    logic [TN_W-1:0]  rec_tnew  [3];
    logic [REG_W-1:0] rec_rs    [3];
    logic [REG_W-1:0] rec_rt    [3];
    logic             rec_live  [3];

    logic             e_bubble;
    logic [REG_W-1:0] d_src  [2];
    logic [TN_W-1:0]  d_tuse [2];
    logic             d_haz  [2];
    fwd_sel_e         d_fwd  [2];
    logic [REG_W-1:0] e_src  [2];
    fwd_sel_e         e_fwd  [2];
    logic             hit;
    logic [TN_W-1:0]  hit_tnew;
    fwd_sel_e         hit_sel;

    assign e_bubble = stall | ~id_valid;

    hzd_stage_rec #(.TN_W(TN_W), .DEC_TNEW(1'b0)) u_rec_e (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (e_bubble),
        .in_valid(id_valid),
        .in_wen  (id_wen),
        .in_dst  (id_wdst),
        .in_tnew (id_tninit),
        .in_rs   (id_rs),
        .in_rt   (id_rt),
        .q_valid (rec_valid[0]),
        .q_wen   (rec_wen[0]),
        .q_dst   (rec_dst[0]),
        .q_tnew  (rec_tnew[0]),
        .q_rs    (rec_rs[0]),
        .q_rt    (rec_rt[0])
    );

    hzd_stage_rec #(.TN_W(TN_W), .DEC_TNEW(1'b1)) u_rec_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .in_valid(rec_valid[0]),
        .in_wen  (rec_wen[0]),
        .in_dst  (rec_dst[0]),
        .in_tnew (rec_tnew[0]),
        .in_rs   (rec_rs[0]),
        .in_rt   (rec_rt[0]),
        .q_valid (rec_valid[1]),
        .q_wen   (rec_wen[1]),
        .q_dst   (rec_dst[1]),
        .q_tnew  (rec_tnew[1]),
        .q_rs    (rec_rs[1]),
        .q_rt    (rec_rt[1])
    );

    hzd_stage_rec #(.TN_W(TN_W), .DEC_TNEW(1'b1)) u_rec_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .bubble  (1'b0),
        .in_valid(rec_valid[1]),
        .in_wen  (rec_wen[1]),
        .in_dst  (rec_dst[1]),
        .in_tnew (rec_tnew[1]),
        .in_rs   (rec_rs[1]),
        .in_rt   (rec_rt[1]),
        .q_valid (rec_valid[2]),
        .q_wen   (rec_wen[2]),
        .q_dst   (rec_dst[2]),
        .q_tnew  (rec_tnew[2]),
        .q_rs    (rec_rs[2]),
        .q_rt    (rec_rt[2])
    );

    always_comb begin
        for (int unsigned k = 0; k < 3; k++) begin
            rec_live[k] = rec_valid[k] & rec_wen[k] & (rec_dst[k] != '0);
        end
        d_src[0]  = id_rs;
        d_src[1]  = id_rt;
        d_tuse[0] = id_tuse_rs;
        d_tuse[1] = id_tuse_rt;
        e_src[0]  = rec_rs[0];
        e_src[1]  = rec_rt[0];
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_sel   = FWD_GRF;

        for (int unsigned s = 0; s < 2; s++) begin
            hit      = 1'b0;
            hit_tnew = '0;
            hit_sel  = FWD_GRF;
            // Scan oldest to youngest so the youngest matching writer wins.
            if (d_src[s] != '0 && d_tuse[s] != TN_W'(TUSE_NONE)) begin
                for (int unsigned j = 0; j < 3; j++) begin
                    if (rec_live[2-j] && rec_dst[2-j] == d_src[s]) begin
                        hit      = 1'b1;
                        hit_tnew = rec_tnew[2-j];
                        hit_sel  = stage_fwd(2 - j);
                    end
                end
            end
            d_haz[s] = hit && (hit_tnew > d_tuse[s]);
            d_fwd[s] = (hit && hit_tnew == '0) ? hit_sel : FWD_GRF;

            e_fwd[s] = FWD_GRF;
            if (rec_valid[0] && e_src[s] != '0) begin
                if (rec_live[2] && rec_dst[2] == e_src[s] && rec_tnew[2] == '0)
                    e_fwd[s] = FWD_W;
                if (rec_live[1] && rec_dst[1] == e_src[s] && rec_tnew[1] == '0)
                    e_fwd[s] = FWD_M;
            end
        end

        stall    = id_valid & (d_haz[0] | d_haz[1]);
        fwd_d_rs = d_fwd[0];
        fwd_d_rt = d_fwd[1];
        fwd_e_rs = e_fwd[0];
        fwd_e_rt = e_fwd[1];
        fwd_m_rt = (rec_live[2] && rec_dst[2] == rec_rt[1]) ? FWD_W : FWD_GRF;
    end

`ifdef HZD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hzd_unit.sv
// Self-checking bench for hzd_unit: directed vector table, reset sequence and
// randomized traffic against an instruction-age reference model.
module tb_hzd_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs, id_rt;
    logic [1:0] id_tuse_rs, id_tuse_rt;
    logic       id_wen;
    logic [4:0] id_wdst;
    logic [1:0] id_tninit;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;
`ifdef HZD_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    hzd_unit #(.TN_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_tuse_rs(id_tuse_rs),
        .id_tuse_rt(id_tuse_rt),
        .id_wen    (id_wen),
        .id_wdst   (id_wdst),
        .id_tninit (id_tninit),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .fwd_m_rt  (fwd_m_rt)
`ifdef HZD_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int v, rs, rt, tu_rs, tu_rt, wen, wdst, tni;
        int st, fdrs, fdrt, fers, fert, fmrt;
    } vec_t;

    typedef struct {
        int v, wen, dst, tninit, rs, rt;
    } ins_t;

    vec_t tbl [23];
    ins_t pipe [3];
    ins_t bub = '{0, 0, 0, 0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v, rs, rt, tu_rs, tu_rt, wen, wdst, tni,
                                input int st, fdrs, fdrt, fers, fert, fmrt);
        vec_t r;
        r = '{v, rs, rt, tu_rs, tu_rt, wen, wdst, tni, st, fdrs, fdrt, fers, fert, fmrt};
        return r;
    endfunction

    task automatic drive(input int v, rs, rt, tu_rs, tu_rt, wen, wdst, tni);
        id_valid   = v[0];
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_tuse_rs = 2'(tu_rs);
        id_tuse_rt = 2'(tu_rt);
        id_wen     = wen[0];
        id_wdst    = 5'(wdst);
        id_tninit  = 2'(tni);
    endtask

    task automatic check_all(input string tag, input int st, fdrs, fdrt, fers, fert, fmrt);
        check({tag, "_stall"}, int'(stall), st);
        check({tag, "_fwd_d_rs"}, int'(fwd_d_rs), fdrs);
        check({tag, "_fwd_d_rt"}, int'(fwd_d_rt), fdrt);
        check({tag, "_fwd_e_rs"}, int'(fwd_e_rs), fers);
        check({tag, "_fwd_e_rt"}, int'(fwd_e_rt), fert);
        check({tag, "_fwd_m_rt"}, int'(fwd_m_rt), fmrt);
    endtask

    // Reference model: a record's Tnew is its Tnew at entry minus its age.
    function automatic int tnew_at(input int k);
        int t;
        t = pipe[k].tninit - k;
        return (t < 0) ? 0 : t;
    endfunction

    function automatic bit live(input int k);
        return pipe[k].v != 0 && pipe[k].wen != 0 && pipe[k].dst != 0;
    endfunction

    task automatic model_d(input int src, input int tuse, output int haz, output int fwd);
        haz = 0;
        fwd = 0;
        if (src == 0 || tuse == 3) return;
        for (int k = 0; k < 3; k++) begin
            if (live(k) && pipe[k].dst == src) begin
                haz = (tnew_at(k) > tuse) ? 1 : 0;
                fwd = (tnew_at(k) == 0) ? k + 1 : 0;
                return;
            end
        end
    endtask

    function automatic int model_e(input int src);
        if (pipe[0].v == 0 || src == 0) return 0;
        for (int k = 1; k < 3; k++)
            if (live(k) && pipe[k].dst == src && tnew_at(k) == 0) return k + 1;
        return 0;
    endfunction

    task automatic do_reset();
        drive(0, 0, 0, 3, 3, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int h_rs, h_rt, f_rs, f_rt, est, mcnt;
        int pool [5];
        ins_t nw;
        int v, rs, rt, turs, turt, wen, wdst, tni;

        pool = '{0, 5, 7, 31, 5};

        // Load-use, ALU->branch, jal->jr, $0 writer, E/M priority, load->branch
        tbl[0]  = mk(1, 29, 8, 1, 3, 1, 8, 2,   0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 8, 9, 1, 1, 1, 10, 1,   1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8, 9, 1, 1, 1, 10, 1,   0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 3, 0, 0);
        tbl[4]  = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 9, 1, 3, 1, 9, 1,    0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 9, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 9, 0, 0, 0, 0, 0, 0,    0, 2, 0, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 3, 3, 1, 31, 0,   0, 0, 0, 3, 0, 0);
        tbl[10] = mk(1, 31, 0, 0, 3, 0, 0, 0,   0, 1, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 2, 1, 1, 1, 0, 1,    0, 0, 0, 2, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 2, 1, 1, 1, 5, 1,    0, 0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 5, 1, 3, 1, 5, 1,    0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 5, 0, 2, 3, 0, 0, 0,    0, 0, 0, 0, 2, 0);
        tbl[16] = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 2, 0, 3);
        tbl[17] = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 7, 1, 3, 1, 7, 2,    0, 0, 0, 0, 0, 0);
        tbl[19] = mk(1, 7, 7, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        tbl[20] = mk(1, 7, 7, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
        tbl[21] = mk(1, 7, 7, 0, 0, 0, 0, 0,    0, 3, 3, 0, 0, 0);
        tbl[22] = mk(0, 0, 0, 3, 3, 0, 0, 0,    0, 0, 0, 0, 0, 0);

        // Reset state, with a D instruction that would hit if records were live
        rst_n = 1'b0;
        drive(1, 8, 8, 0, 0, 1, 8, 2);
        #3;
        check_all("reset", 0, 0, 0, 0, 0, 0);
`ifdef HZD_STALL_CNT_EN
        check("reset_cnt", int'(stall_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].tu_rs, tbl[i].tu_rt,
                  tbl[i].wen, tbl[i].wdst, tbl[i].tni);
            #1;
            check_all($sformatf("v%0d", i), tbl[i].st, tbl[i].fdrs, tbl[i].fdrt,
                      tbl[i].fers, tbl[i].fert, tbl[i].fmrt);
            @(negedge clk);
        end
`ifdef HZD_STALL_CNT_EN
        check("tbl_cnt", int'(stall_cnt), 4);
`endif

        // Reset asserted in the middle of a load->branch stall
        drive(1, 0, 8, 1, 3, 1, 8, 2);
        @(negedge clk);
        drive(1, 8, 0, 0, 3, 0, 0, 0);
        #1;
        check("rs_pre_stall", int'(stall), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("rs_async", 0, 0, 0, 0, 0, 0);
`ifdef HZD_STALL_CNT_EN
        check("rs_async_cnt", int'(stall_cnt), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rs_after_stall", int'(stall), 0);
        drive(1, 0, 8, 1, 3, 1, 8, 2);
        @(negedge clk);
        drive(1, 8, 9, 1, 1, 1, 10, 1);
        #1;
        check("rs_lu_stall", int'(stall), 1);
        @(negedge clk);
        #1;
        check_all("rs_lu_b", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 3, 3, 0, 0, 0);
        #1;
        check_all("rs_lu_c", 0, 0, 0, 3, 0, 0);
`ifdef HZD_STALL_CNT_EN
        check("rs_lu_cnt", int'(stall_cnt), 1);
`endif

        // Randomized traffic against the age-based model
        @(negedge clk);
        do_reset();
        for (int k = 0; k < 3; k++) pipe[k] = bub;
        mcnt = 0;
        for (int c = 0; c < 600; c++) begin
            v    = ($urandom_range(0, 9) < 8) ? 1 : 0;
            rs   = pool[$urandom_range(0, 4)];
            rt   = pool[$urandom_range(0, 4)];
            turs = $urandom_range(0, 3);
            turt = $urandom_range(0, 3);
            wen  = $urandom_range(0, 1);
            wdst = pool[$urandom_range(0, 4)];
            tni  = $urandom_range(0, 2);
            drive(v, rs, rt, turs, turt, wen, wdst, tni);
            #1;
            model_d(rs, turs, h_rs, f_rs);
            model_d(rt, turt, h_rt, f_rt);
            est = (v != 0 && (h_rs != 0 || h_rt != 0)) ? 1 : 0;
            check_all($sformatf("rnd%0d", c), est, f_rs, f_rt,
                      model_e(pipe[0].rs), model_e(pipe[0].rt),
                      (live(2) && pipe[2].dst == pipe[1].rt) ? 3 : 0);
`ifdef HZD_STALL_CNT_EN
            check($sformatf("rnd%0d_cnt", c), int'(stall_cnt), mcnt);
`endif
            if ($urandom_range(0, 49) == 0) begin
                #1;
                rst_n = 1'b0;
                drive(0, 0, 0, 3, 3, 0, 0, 0);
                #1;
                check_all($sformatf("rnd%0d_rst", c), 0, 0, 0, 0, 0, 0);
                #1;
                rst_n = 1'b1;
                for (int k = 0; k < 3; k++) pipe[k] = bub;
                mcnt = 0;
            end else begin
                nw = '{v, wen, wdst, tni, rs, rt};
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = (est != 0 || v == 0) ? bub : nw;
                mcnt += est;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hzd_unit.md
# hzd_unit

Tnew/Tuse hazard unit for the five-stage MIPS pipeline. It sits beside the D stage, directly downstream of the main decoder (`ctl`). It consumes the decoder's `GRFwen`, the resolved destination register and `TNinit` for the instruction in D, and keeps a per-stage record pipeline for E/M/W. From these records it produces the F/D stall and all forwarding selects.

## Interface
Parameters:
- `TN_W`, 2, width of the Tnew/Tuse fields.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `id_valid` in 1: D holds a real instruction.
- `id_rs`, `id_rt` in 5 each: D-stage source register numbers.
- `id_tuse_rs`, `id_tuse_rt` in TN_W each: cycles until the operand is needed. 0 means used in D (branch/`jr`), 1 means E, 2 means M (store data). 3 (`TUSE_NONE`) means the operand is not read.
- `id_wen` in 1: `GRFwen` of the D instruction.
- `id_wdst` in 5: resolved destination register (rd/rt/31).
- `id_tninit` in TN_W: `TNinit` of the D instruction.
- `stall` out 1: hold PC and F/D, and insert a bubble into E.
- `fwd_d_rs`, `fwd_d_rt` out 2 each: D-stage operand source. 0 = GRF, 1 = E, 2 = M, 3 = W.
- `fwd_e_rs`, `fwd_e_rt` out 2 each: E-stage operand source. 0 = pipeline register, 2 = M, 3 = W.
- `fwd_m_rt` out 2: DM write-data source. 0 = pipeline register, 3 = W.

## Operation
- Records E, M, W each hold {valid, wen, dst, tnew, rs, rt}.
- A record is a live writer iff valid & wen & dst≠0.
- On each rising edge, with no reset:
  - W ← M, with tnew saturating-decremented.
  - M ← E, with tnew saturating-decremented.
  - If stall=1 or id_valid=0: E ← bubble (valid=0).
  - Otherwise: E ← {1, id_wen, id_wdst, id_tninit, id_rs, id_rt}.
- Source match, evaluated per D source s ∈ {rs, rt}. It applies only when s≠0 and tuse_s≠3. The youngest live writer in E, then M, then W whose dst==s wins.
- Stall: stall = id_valid & (some D source's winning match X has tnew_X > tuse_s).
  - Only the youngest match is considered.
  - W always has tnew=0, so W never causes a stall.
- D forward: if the winning match has tnew=0, `fwd_d_s` selects that stage. Otherwise 0.
  - E is selectable only for tnew=0 at entry (jal PC+8).
- E forward, per E-record source: youngest of M, then W, that is a live writer with dst==source and tnew=0. Source 0 never forwards. If E is invalid, the output is 0.
- M forward, for the M-record rt: W live writer with dst==rt gives 3. Otherwise 0.
- Tnew arithmetic: TN_W-bit unsigned. Decrement saturates at 0 and never wraps.
- Simultaneous stall and forward: when stall=1, the fwd_d outputs are don't-care but must still follow the rule above.
- Reset mid-operation: all records are invalidated immediately (asynchronously). The next instruction enters E normally.

## Timing
- `stall` and all `fwd_*` outputs are combinational from the D inputs and the registered records. Latency is 0 cycles.
- Record update takes 1 cycle per stage.
- A load entering E (tnew=2):
  - Stalls a dependent D instruction with tuse=1 for exactly 1 cycle.
  - Stalls a dependent D instruction with tuse=0 for exactly 2 cycles.
- Reset values: stall=0, all fwd_*=0, all records valid=0, tnew=0.

## Configuration
- Macro `HZD_STALL_CNT_EN`.
- Defined: adds output `stall_cnt` (32-bit).
  - Increments on each rising edge where stall=1 and saturates at 0xFFFFFFFF.
  - Reset value is 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared header `hzd.vh`, included like `mips.vh`. It holds:
  - `FWD_GRF`=0, `FWD_E`=1, `FWD_M`=2, `FWD_W`=3.
  - `TUSE_NONE`=3.
  - The record field widths.
- One sub-module, `hzd_stage_rec`. It is a single record register with async clear, saturating tnew decrement and a bubble input, and is instantiated three times.

## Test plan
- Load then ALU use: `lw $8` (tninit=2) in E, with `addu` in D (rs=8, tuse=1).
  - Expected: stall=1 for 1 cycle.
  - Next cycle: fwd_e_rs=2 is invalid because the load is still producing, so M tnew=1. The cycle after that: fwd_e_rs=3.
- ALU then branch: `ori $9` (tninit=1) in E, with `beq` in D (rs=9, tuse=0).
  - Expected: stall for 1 cycle, then fwd_d_rs=2.
- JAL then jr: `jal` in E (tnew=0), with `jr $31` in D.
  - Expected: stall=0, fwd_d_rs=1.
- Register zero: writer has dst=0, with D rs=0.
  - Expected: stall=0 and fwd_d_rs=0.
- Priority: E and M both write $5, with D rs=5 and tuse=2.
  - Expected: E tnew=1 ≤ 2, so there is no stall. fwd_d_rs=0, because the E match has tnew≠0 and the older M match is ignored.
- Reset: assert rst_n=0 mid-stall.
  - Expected: stall=0 immediately. With `HZD_STALL_CNT_EN` defined, stall_cnt=0.
